// File: rtl/mem_bus_arbiter_pkg.sv
// openmips_pkg: arbiter state encoding and parameter defaults shared by the arbiter files
package openmips_pkg;
    typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER, DONE} arb_state_e;
    localparam int FAIR_LIMIT_DEF = 4;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch port, data port and shared memory bus; bus_err exists only with ARB_TIMEOUT_EN
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_sel;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_if;
    logic        stall_mem;
`ifdef ARB_TIMEOUT_EN
    logic        bus_err;
`endif
    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_sel, bus_rdata, bus_ack,
        output if_rdata, if_ack, dm_rdata, dm_ack, bus_stb, bus_we, bus_addr, bus_wdata, bus_sel,
               stall_if, stall_mem
`ifdef ARB_TIMEOUT_EN
        , bus_err
`endif
    );
    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_sel, bus_rdata, bus_ack,
        input  if_rdata, if_ack, dm_rdata, dm_ack, bus_stb, bus_we, bus_addr, bus_wdata, bus_sel,
               stall_if, stall_mem
`ifdef ARB_TIMEOUT_EN
        , bus_err
`endif
    );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// arb_watchdog: flags a transfer that has been outstanding for TIMEOUT cycles
module arb_watchdog
    import openmips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    // count cycles of the current transfer; cleared whenever no transfer is outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else cnt <= run ? cnt + 1'b1 : '0;
    end
    assign expire = run && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates fetch and data requests onto one memory bus with fetch starvation guard;
// defining ARB_TIMEOUT_EN adds a bus watchdog and the bus_err flag
module mem_bus_arbiter
    import openmips_pkg::*;
#(
    parameter int FAIR_LIMIT = FAIR_LIMIT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clk,
    input logic reset,
    mem_bus_arbiter_if.master arb
);
    localparam int FW = $clog2(FAIR_LIMIT + 1);
    if (FAIR_LIMIT < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_bus_arbiter: FAIR_LIMIT and TIMEOUT must be positive");
    end
    arb_state_e state;
    logic [FW-1:0] fair_cnt;
    logic fin;
    logic dm_win;
    logic [31:0] rd;
`ifdef ARB_TIMEOUT_EN
    logic expire;
    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(clk),
        .reset(reset),
        .run(state == IF_XFER || state == DM_XFER),
        .expire(expire)
    );
    assign fin = arb.bus_ack | expire;
`else
    assign fin = arb.bus_ack;
`endif
    // a timed-out transfer returns zero data
    assign rd = arb.bus_ack ? arb.bus_rdata : '0;
    // data wins unless fetch has already waited through FAIR_LIMIT data grants
    assign dm_win = arb.dm_req && !(arb.if_req && fair_cnt == FW'(FAIR_LIMIT));
    assign arb.stall_if = arb.if_req & ~arb.if_ack;
    assign arb.stall_mem = arb.dm_req & ~arb.dm_ack;
    // grant, hold the latched bus fields until completion, pulse the ack, then one DONE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            fair_cnt <= '0;
            arb.bus_stb <= 1'b0;
            arb.bus_we <= 1'b0;
            arb.bus_addr <= '0;
            arb.bus_wdata <= '0;
            arb.bus_sel <= '0;
            arb.if_rdata <= '0;
            arb.if_ack <= 1'b0;
            arb.dm_rdata <= '0;
            arb.dm_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            arb.bus_err <= 1'b0;
`endif
        end else begin
            arb.if_ack <= 1'b0;
            arb.dm_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            arb.bus_err <= 1'b0;
`endif
            if (!arb.if_req) fair_cnt <= '0;
            case (state)
                IDLE: begin
                    if (dm_win) begin
                        state <= DM_XFER;
                        arb.bus_stb <= 1'b1;
                        arb.bus_we <= arb.dm_we;
                        arb.bus_addr <= arb.dm_addr;
                        arb.bus_wdata <= arb.dm_wdata;
                        arb.bus_sel <= arb.dm_sel;
                        if (arb.if_req) fair_cnt <= fair_cnt + 1'b1;
                    end else if (arb.if_req) begin
                        state <= IF_XFER;
                        arb.bus_stb <= 1'b1;
                        arb.bus_we <= 1'b0;
                        arb.bus_addr <= arb.if_addr;
                        arb.bus_wdata <= '0;
                        arb.bus_sel <= 4'hF;
                        fair_cnt <= '0;
                    end
                end
                IF_XFER, DM_XFER: begin
                    if (fin) begin
                        state <= DONE;
                        arb.bus_stb <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        arb.bus_err <= ~arb.bus_ack;
`endif
                        if (state == IF_XFER && arb.if_req) begin
                            arb.if_ack <= 1'b1;
                            arb.if_rdata <= rd;
                        end
                        if (state == DM_XFER && arb.dm_req) begin
                            arb.dm_ack <= 1'b1;
                            arb.dm_rdata <= rd;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, fairness, completion, reset and (with ARB_TIMEOUT_EN) timeout
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_err = 0;
    int wait_n = 1;
    bit resp_en = 1'b1;
    bit force_ack = 1'b0;
    int rcnt = 0;
    int unstable = 0;
    logic prev_stb = 1'b0;
    logic [68:0] held = '0;
    int d;
    int n;

    mem_bus_arbiter_if bus ();
    mem_bus_arbiter #(.FAIR_LIMIT(4), .TIMEOUT(8)) dut (.clk(clk), .reset(reset), .arb(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit fetch, input string tag);
        int k = 0;
        while (!(fetch ? bus.if_ack : bus.dm_ack) && k < 40) begin
            tick();
            k++;
        end
        chk(tag, 32'(fetch ? bus.if_ack : bus.dm_ack), 1);
    endtask

    // memory model: acks after wait_n wait states; data is 3402_0001 at 0x100, else ~addr
    initial begin
        bus.bus_ack = 1'b0;
        bus.bus_rdata = '0;
        forever begin
            tick();
            if (bus.bus_stb && resp_en && rcnt == wait_n) begin
                bus.bus_ack = 1'b1;
                bus.bus_rdata = (bus.bus_addr == 32'h100) ? 32'h3402_0001 : ~bus.bus_addr;
                rcnt = 0;
            end else begin
                bus.bus_ack = force_ack;
                rcnt = bus.bus_stb ? rcnt + 1 : 0;
            end
        end
    end

    // bus fields must not change while a strobe is held
    initial begin
        forever begin
            tick();
            if (bus.bus_stb && prev_stb && {bus.bus_we, bus.bus_sel, bus.bus_addr, bus.bus_wdata} != held)
                unstable++;
            held = {bus.bus_we, bus.bus_sel, bus.bus_addr, bus.bus_wdata};
            prev_stb = bus.bus_stb;
        end
    end

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        bus.dm_addr = '0;
        bus.dm_wdata = '0;
        bus.dm_sel = '0;
        tick();
        tick();
        chk("rst_stb", 32'(bus.bus_stb), 0);
        chk("rst_acks", 32'({bus.if_ack, bus.dm_ack}), 0);
        chk("rst_rdata", bus.if_rdata | bus.dm_rdata, 0);
        reset = 1'b0;
        tick();

        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        tick();
        chk("f_stb1", 32'(bus.bus_stb), 1);
        chk("f_addr", bus.bus_addr, 32'h100);
        chk("f_we_sel", 32'({bus.bus_we, bus.bus_sel}), 32'h0F);
        chk("f_stall", 32'(bus.stall_if), 1);
        tick();
        chk("f_stb2", 32'(bus.bus_stb), 1);
        chk("f_noack", 32'(bus.if_ack), 0);
        tick();
        chk("f_ack", 32'(bus.if_ack), 1);
        chk("f_stb_off", 32'(bus.bus_stb), 0);
        chk("f_rdata", bus.if_rdata, 32'h3402_0001);
        chk("f_stall_ack", 32'(bus.stall_if), 0);
        bus.if_req = 1'b0;
        tick();
        chk("f_pulse", 32'(bus.if_ack), 0);

        bus.if_addr = 32'h200;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b1;
        bus.dm_addr = 32'h40;
        bus.dm_wdata = 32'hDEAD_BEEF;
        bus.dm_sel = 4'hF;
        tick();
        chk("s_we", 32'(bus.bus_we), 1);
        chk("s_addr", bus.bus_addr, 32'h40);
        chk("s_wdata", bus.bus_wdata, 32'hDEAD_BEEF);
        wait_ack(1'b0, "s_dm_ack");
        bus.dm_req = 1'b0;
        tick();
        tick();
        chk("s_if_grant", 32'({bus.bus_stb, bus.bus_we}), 2);
        chk("s_if_addr", bus.bus_addr, 32'h200);
        wait_ack(1'b1, "s_if_ack");
        chk("s_if_rdata", bus.if_rdata, 32'hFFFF_FDFF);
        bus.if_req = 1'b0;
        tick();

        bus.if_addr = 32'h300;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b0;
        bus.dm_addr = 32'h80;
        d = 0;
        n = 0;
        while (!bus.if_ack && n < 200) begin
            tick();
            n++;
            if (bus.dm_ack) d++;
        end
        chk("fair_grants", d, 4);
        chk("fair_rdata", bus.if_rdata, 32'hFFFF_FCFF);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        tick();
        tick();

        wait_n = 2;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b1;
        bus.dm_sel = 4'b0011;
        bus.dm_addr = 32'h44;
        bus.dm_wdata = 32'h1234_5678;
        tick();
        chk("w_sel", 32'(bus.bus_sel), 3);
        chk("w_we", 32'(bus.bus_we), 1);
        chk("w_stall", 32'(bus.stall_mem), 1);
        tick();
        chk("w_stall_wait", 32'(bus.stall_mem), 1);
        wait_ack(1'b0, "w_ack");
        chk("w_stall_ack", 32'(bus.stall_mem), 0);
        chk("w_rdata", bus.dm_rdata, 32'hFFFF_FFBB);
        bus.dm_req = 1'b0;
        tick();
        chk("w_pulse", 32'(bus.dm_ack), 0);
        chk("w_hold", bus.dm_rdata, 32'hFFFF_FFBB);

        force_ack = 1'b1;
        tick();
        tick();
        chk("idle_ack", 32'({bus.if_ack, bus.dm_ack, bus.bus_stb}), 0);
        chk("idle_rdata", bus.dm_rdata, 32'hFFFF_FFBB);
        force_ack = 1'b0;
        tick();
        tick();

        bus.dm_req = 1'b1;
        bus.dm_we = 1'b0;
        bus.dm_addr = 32'h48;
        tick();
        chk("drop_grant", 32'(bus.bus_stb), 1);
        bus.dm_req = 1'b0;
        d = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.dm_ack) d++;
        end
        chk("drop_noack", d, 0);
        chk("drop_done", 32'(bus.bus_stb), 0);
        chk("drop_rdata", bus.dm_rdata, 32'hFFFF_FFBB);

        wait_n = 20;
        bus.if_addr = 32'h500;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        bus.dm_addr = 32'h60;
        tick();
        chk("r_grant", bus.bus_addr, 32'h60);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("r_stb_async", 32'(bus.bus_stb), 0);
        chk("r_rdata", bus.if_rdata | bus.dm_rdata, 0);
        tick();
        reset = 1'b0;
        bus.dm_req = 1'b0;
        wait_n = 1;
        tick();
        chk("r_no_dm_ack", 32'(bus.dm_ack), 0);
        wait_ack(1'b1, "r_if_ack");
        chk("r_if_rdata", bus.if_rdata, 32'hFFFF_FAFF);
        bus.if_req = 1'b0;
        tick();
        tick();

`ifdef ARB_TIMEOUT_EN
        resp_en = 1'b0;
        bus.if_addr = 32'h600;
        bus.if_req = 1'b1;
        n = 0;
        d = 0;
        while (!bus.bus_err && d < 40) begin
            tick();
            d++;
            if (bus.bus_stb) n++;
        end
        chk("to_stb_cycles", n, 8);
        chk("to_ack", 32'(bus.if_ack), 1);
        chk("to_rdata", bus.if_rdata, 0);
        bus.if_req = 1'b0;
        tick();
        chk("to_err_pulse", 32'(bus.bus_err), 0);
        resp_en = 1'b1;
        tick();
`endif

        chk("bus_stable", unstable, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: FAIR_LIMIT, 4, max consecutive data grants while fetch waits.
REQ-002 Parameter: TIMEOUT, 255, watchdog limit in cycles, active only with ARB_TIMEOUT_EN.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  fetch read request, held high until if_ack.
REQ-006 if_addr  in  32  fetch word address.
REQ-007 if_rdata  out  32  fetch read data.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 dm_req, dm_we  in  1,1  data request and write-enable, held until dm_ack.
REQ-010 dm_addr, dm_wdata  in  32,32  data address and write data.
REQ-011 dm_sel  in  4  byte lane select.
REQ-012 dm_rdata  out  32  data read data; dm_ack  out  1  one-cycle completion pulse.
REQ-013 bus_stb, bus_we  out  1,1  shared memory strobe and write-enable.
REQ-014 bus_addr, bus_wdata  out  32,32  bus address and write data; bus_sel  out  4  byte lanes.
REQ-015 bus_rdata  in  32  read data; bus_ack  in  1  transfer done.
REQ-016 stall_if, stall_mem  out  1,1  pipeline freeze requests.
REQ-017 bus_err  out  1  timeout flag, present only with ARB_TIMEOUT_EN.

Function
REQ-018 FSM states: IDLE, IF_XFER, DM_XFER, DONE; all outputs are registered except stall_if and stall_mem.
REQ-019 IDLE with dm_req=1 SHALL go to DM_XFER, unless if_req=1 and fair_cnt==FAIR_LIMIT, in which case it goes to IF_XFER.
REQ-020 IDLE with only if_req=1 SHALL go to IF_XFER; with no request it stays in IDLE with bus_stb=0.
REQ-021 On the grant edge, bus_stb=1 and the granted requester's addr/we/wdata/sel SHALL be latched; fetch uses bus_we=0 and bus_sel=4'hF.
REQ-022 Bus outputs SHALL hold stable until the cycle bus_ack=1 is sampled.
REQ-023 On the bus_ack edge: bus_stb=0, bus_rdata captured into the granter's rdata, the granter's ack=1 for exactly one cycle, and the FSM moves to DONE.
REQ-024 DONE SHALL return to IDLE next cycle, so minimum latency from req to ack is 2 cycles plus bus wait states.
REQ-025 fair_cnt SHALL increment on each data grant made while if_req=1 (saturating at FAIR_LIMIT), and clear on any fetch grant or when if_req=0.
REQ-026 stall_if = if_req & ~if_ack; stall_mem = dm_req & ~dm_ack (combinational).
REQ-027 rdata outputs SHALL retain their value until the next completion for the same requester.
REQ-028 bus_ack while in IDLE or DONE SHALL be ignored.
REQ-029 A request dropped before its ack SHALL still complete the bus transfer and suppress the ack pulse.

Reset
REQ-030 reset=1 SHALL immediately force state=IDLE, fair_cnt=0, and all outputs to 0, including bus_stb, acks, rdata and bus_err.
REQ-031 Reset mid-transfer SHALL abort with no ack; after reset release, arbitration restarts from IDLE.

Configuration
REQ-032 With ARB_TIMEOUT_EN defined:
- A cycle counter runs in IF_XFER/DM_XFER.
- When it reaches TIMEOUT without bus_ack, bus_stb drops, bus_err=1 for one cycle, the granter's ack pulses with rdata=32'h0, and the FSM goes to DONE.
REQ-033 Without ARB_TIMEOUT_EN, the bus_err port and counter are absent, and the FSM waits indefinitely for bus_ack.

Structure
REQ-034 The state encoding enum and the FAIR_LIMIT/TIMEOUT defaults SHALL live in shared package openmips_pkg.
REQ-035 The watchdog SHALL be sub-module arb_watchdog, instantiated only under ARB_TIMEOUT_EN; everything else stays flat.

Verification
REQ-036 Fetch only: if_req=1, if_addr=32'h100, bus_ack after 1 wait, bus_rdata=32'h3402_0001 -> bus_stb 2 cycles, if_ack pulse, if_rdata=32'h3402_0001.
REQ-037 Simultaneous if_req and dm_req (dm_we=1, dm_addr=32'h40, dm_wdata=32'hDEAD_BEEF, dm_sel=4'hF) -> data granted first (bus_we=1), then fetch.
REQ-038 Continuous dm_req with if_req held, FAIR_LIMIT=4 -> fetch granted after exactly 4 data grants.
REQ-039 Reset asserted mid-DM_XFER -> bus_stb=0 same cycle, no dm_ack; after release, the pending if_req completes normally.
REQ-040 With ARB_TIMEOUT_EN and TIMEOUT=8, bus_ack never asserted -> bus_err pulse on cycle 8, if_ack with if_rdata=0, FSM back in IDLE 2 cycles later.
REQ-041 Write dm_sel=4'b0011 -> bus_sel=4'b0011, dm_ack pulse, stall_mem high until the ack cycle.
